nonce_scheduler: RTL
====================

Name: nonce_scheduler

Overview:
- Sits in the cluster hub, between the local and external slaves (their nonce buses and golden strobes) and the single serial nonce transmitter.
- Captures golden nonces from all slaves and arbitrates among them round-robin.
- Buffers granted nonces in a small FIFO.
- Sequences the transmitter with a send/busy handshake, so no nonce is lost while the uplink is busy.

Parameters:
- SLAVES, 5, number of nonce sources (local miners plus external ports).
- FIFO_LOG2, 3, log2 of FIFO depth (depth = 8).
- BUSY_TIMEOUT, 15, cycles to wait for serial_busy to rise after a send before giving up.

Ports:
- hash_clk  in  1  sole clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- new_nonces  in  SLAVES  per-slave golden strobe; each high cycle is one event.
- slave_nonces  in  SLAVES*32  slave i nonce at bits [i*32+31:i*32], valid when new_nonces[i]=1.
- golden_nonce  out  32  word presented to the transmitter.
- serial_send  out  1  one-cycle send pulse to the transmitter.
- serial_busy  in  1  transmitter busy.
- fifo_count  out  FIFO_LOG2+1  current FIFO occupancy.
- overflow  out  1  sticky: at least one nonce was lost.
- sent_count  out  16  nonces sent (only with SCHED_STATS_EN).
- drop_count  out  16  nonces lost (only with SCHED_STATS_EN).

Behaviour:
Reset (overrides everything, including mid-transfer):
- golden_nonce=0, serial_send=0, fifo_count=0, overflow=0, counters=0.
- All pending flags clear, FIFO empty, round-robin pointer=0, FSM=IDLE.

Capture stage:
- Per slave: a 32-bit hold register plus a pending flag.
- new_nonces[i]=1: hold[i]<=slave_nonces[i], pending[i]<=1.
- If pending[i] was already 1 and is not granted this cycle: old value overwritten, overflow<=1, one drop counted.

Arbiter:
- Each cycle with FIFO not full and any pending set: grant the first pending slave at or after pointer p, wrapping mod SLAVES.
- On grant: write hold[g] to the FIFO, clear pending[g], set p<=(g+1) mod SLAVES.
- Grant to slave g and new_nonces[g] in the same cycle: the old value goes to the FIFO, the new value is loaded, pending stays 1, no overflow.
- FIFO full: no grant, pending flags and pointer hold.
- At most one FIFO write per cycle.

FIFO:
- 2^FIFO_LOG2 entries, circular pointers with wrap-around.
- Simultaneous push and pop permitted, including when full (pop frees the slot in the same cycle) and when non-empty.
- No push when full, no pop when empty.

TX FSM:
- IDLE: if FIFO non-empty and serial_busy=0, pop the head into golden_nonce, then go to SEND.
- SEND: serial_send=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: when serial_busy=1, go to WAIT_DONE. Otherwise count cycles; after BUSY_TIMEOUT cycles go to IDLE (nonce treated as sent).
- WAIT_DONE: when serial_busy=0, go to IDLE.
- golden_nonce is stable from load until the next pop.
- If reset occurs while the transmitter is busy, IDLE waits for serial_busy=0 before the next send.

Latency (empty system, transmitter idle):
- Strobe in cycle N, pending set in N+1, granted in N+1.
- FIFO non-empty in N+2, popped in N+2.
- golden_nonce valid and serial_send=1 in cycle N+3.

Optional Feature:
Macro: SCHED_STATS_EN
- Defined:
  - sent_count increments on each SEND state.
  - drop_count increments on each overwrite loss.
  - Both saturate at 16'hFFFF.
- Undefined: sent_count and drop_count are tied to 0 and no counter logic is built. overflow behaves identically either way.

Test Plan:
- Single nonce: new_nonces=5'b00001, slave 0 nonce=32'hDEADBEEF in cycle 0, serial_busy idle. Expect serial_send=1 in cycle 3 with golden_nonce=DEADBEEF; hold serial_busy=1 for 20 cycles, then 0; FSM back to IDLE; fifo_count=0.
- Round-robin order: all 5 slaves strobe together with nonces 0x10–0x14, serial_busy always 0. Expect sends in order 0x10,0x11,0x12,0x13,0x14, one per handshake. Next simultaneous burst starts at slave 0 again (pointer 0 after slave 4).
- Full FIFO: serial_busy held 1; strobe slave 2 eleven times, each after the prior grant. Expect fifo_count saturates at 8, pending[2]=1 with the 9th value, the 10th and 11th overwrite it: overflow=1, drop_count=2 (stats build). After releasing busy, 9 nonces are sent.
- Grant collision: slave 1 pending with 0xA, new strobe 0xB in the grant cycle. Expect 0xA then 0xB sent, overflow stays 0.
- Busy timeout: serial_busy never rises. Expect return to IDLE 15 cycles after SEND, next FIFO entry sent; sent_count=2.
- Reset mid-transfer: assert reset in WAIT_DONE with 3 FIFO entries and serial_busy=1. Expect all outputs 0, fifo_count=0; no serial_send until serial_busy falls and a new nonce arrives.

Source files
------------

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - golden nonce capture, round-robin arbitration, FIFO and serial TX sequencing
//
// Ports:
//   hash_clk      sole clock, rising edge
//   reset         synchronous active-high reset
//   new_nonces    per-slave golden strobe, one event per high cycle
//   slave_nonces  slave i nonce at bits [i*32+31:i*32]
//   golden_nonce  word presented to the serial transmitter
//   serial_send   one-cycle send pulse
//   serial_busy   transmitter busy
//   fifo_count    current FIFO occupancy
//   overflow      sticky, at least one nonce was overwritten before grant
//   sent_count    nonces sent, saturating (SCHED_STATS_EN only, else 0)
//   drop_count    nonces lost, saturating (SCHED_STATS_EN only, else 0)
//
// Optional build macro: SCHED_STATS_EN enables the sent/drop counters.
module nonce_scheduler #(
    parameter int SLAVES       = 5,
    parameter int FIFO_LOG2    = 3,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                 hash_clk,
    input  logic                 reset,
    input  logic [SLAVES-1:0]    new_nonces,
    input  logic [SLAVES*32-1:0] slave_nonces,
    output logic [31:0]          golden_nonce,
    output logic                 serial_send,
    input  logic                 serial_busy,
    output logic [FIFO_LOG2:0]   fifo_count,
    output logic                 overflow,
    output logic [15:0]          sent_count,
    output logic [15:0]          drop_count
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [SLAVES-1:0]    pending_q;
    logic [31:0]          hold_q [SLAVES];
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [31:0]          mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]   count_q;
    logic [1:0]           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [31:0]          golden_q;
    logic                 overflow_q;

    logic                 full, pop, push, grant_en, grant_vld;
    logic [PTR_W-1:0]     grant_idx, next_ptr;
    logic [SLAVES-1:0]    grant_oh, drop_mask;

    assign full = (count_q == (FIFO_LOG2+1)'(DEPTH));
    assign pop  = (state_q == ST_IDLE) && (count_q != '0) && !serial_busy;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept a grant.
    assign grant_en = !full || pop;

    // First pending slave at or after the round-robin pointer, wrapping.
    always_comb begin
        int cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < SLAVES; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= SLAVES) cand = cand - SLAVES;
            if (grant_en && !grant_vld && pending_q[PTR_W'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    assign push      = grant_vld;
    assign next_ptr  = (grant_idx == PTR_W'(SLAVES - 1)) ? '0 : grant_idx + 1'b1;
    // A strobe on a slave whose held value is granted this cycle is not a loss.
    assign drop_mask = new_nonces & pending_q & ~grant_oh;

    // The timer counts cycles since the send pulse, including the pulse cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE:      if (pop) state_d = ST_SEND;
            ST_SEND: begin
                state_d = ST_WAIT_BUSY;
                timer_d = TMR_W'(1);
            end
            ST_WAIT_BUSY: begin
                if (serial_busy) state_d = ST_WAIT_DONE;
                else if (timer_q >= TMR_W'(BUSY_TIMEOUT - 1)) state_d = ST_IDLE;
                else timer_d = timer_q + 1'b1;
            end
            ST_WAIT_DONE: if (!serial_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            golden_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= (pending_q & ~grant_oh) | new_nonces;
            overflow_q <= overflow_q | (|drop_mask);
            if (grant_vld) rr_ptr_q <= next_ptr;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                golden_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + (FIFO_LOG2+1)'(push) - (FIFO_LOG2+1)'(pop);
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Data storage needs no reset; validity is carried by pending_q and count_q.
    always_ff @(posedge hash_clk) begin
        for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i]) hold_q[i] <= slave_nonces[i*32 +: 32];
        end
        if (push) mem_q[wr_ptr_q] <= hold_q[grant_idx];
    end

    assign golden_nonce = golden_q;
    assign serial_send  = (state_q == ST_SEND);
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;

`ifdef SCHED_STATS_EN
    localparam int DN_W = $clog2(SLAVES + 1);
    logic [15:0]   sent_q, drop_q;
    logic [DN_W-1:0] drop_num;
    logic [16:0]   drop_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < SLAVES; i++) drop_num = drop_num + DN_W'(drop_mask[i]);
        drop_sum = {1'b0, drop_q} + 17'(drop_num);
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            if (state_q == ST_SEND && sent_q != 16'hFFFF) sent_q <= sent_q + 1'b1;
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign sent_count = sent_q;
    assign drop_count = drop_q;
`else
    assign sent_count = '0;
    assign drop_count = '0;
`endif

endmodule
